// File: rtl/stream_dispatch_pkg.sv
// stream_dispatch_pkg: shared route codes and default UDP ports for the CHDR ingress
// dispatcher. The egress aggregator uses the same port constants.
//   route_t        : 2-bit route code (o0, o1, o2, drop)
//   route_decode() : priority encode of the three port-match flags into a route code
package stream_dispatch_pkg;

    typedef logic [1:0] route_t;

    localparam route_t ROUTE_CTRL = 2'd0;
    localparam route_t ROUTE_TX   = 2'd1;
    localparam route_t ROUTE_RXFC = 2'd2;
    localparam route_t ROUTE_DROP = 2'd3;

    localparam int unsigned UDP_CTRL_PORT   = 49200;
    localparam int unsigned UDP_TXDATA_PORT = 49202;
    localparam int unsigned UDP_RXFC_PORT   = 49204;

    // The lowest output index wins if two ports are configured to the same value.
    function automatic route_t route_decode(input logic hit_ctrl, input logic hit_tx,
                                            input logic hit_rxfc);
        if (hit_ctrl)      return ROUTE_CTRL;
        else if (hit_tx)   return ROUTE_TX;
        else if (hit_rxfc) return ROUTE_RXFC;
        else               return ROUTE_DROP;
    endfunction

endpackage

// File: rtl/stream_dispatch_sat_cnt.sv
// stream_dispatch_sat_cnt: CNT_W-bit event counter that saturates at all-ones.
//   clk     : clock
//   reset_n : synchronous active-low reset (count -> 0)
//   clear   : synchronous soft clear (count -> 0)
//   inc     : count one event this cycle
//   count   : current count
module stream_dispatch_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_dispatch.sv
// stream_dispatch: routes whole CHDR packets from one ingress stream to one of three
// consumers by UDP destination port (i_tuser, sampled on the first beat). Unknown
// ports are drained at one beat per cycle and counted as drops.
//   clk, reset_n, clear         : clock, sync active-low reset, sync soft clear
//   i_tdata/tuser/tlast/tvalid  : ingress stream, i_tready back to the deframer
//   oN_tdata/tlast/tvalid       : egress streams (0 = ctrl, 1 = tx data, 2 = rx fc ack)
//   oN_tready                   : egress ready, only the selected one is honoured
//   drop_count, pkt_count       : saturating packet counters
module stream_dispatch
    import stream_dispatch_pkg::*;
#(
    parameter int unsigned CHDR_W      = 64,
    parameter int unsigned USER_W      = 16,
    parameter int unsigned CTRL_PORT   = UDP_CTRL_PORT,
    parameter int unsigned TXDATA_PORT = UDP_TXDATA_PORT,
    parameter int unsigned RXFC_PORT   = UDP_RXFC_PORT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [CHDR_W-1:0] i_tdata,
    input  logic [USER_W-1:0] i_tuser,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [CHDR_W-1:0] o0_tdata,
    output logic              o0_tlast,
    output logic              o0_tvalid,
    input  logic              o0_tready,
    output logic [CHDR_W-1:0] o1_tdata,
    output logic              o1_tlast,
    output logic              o1_tvalid,
    input  logic              o1_tready,
    output logic [CHDR_W-1:0] o2_tdata,
    output logic              o2_tlast,
    output logic              o2_tvalid,
    input  logic              o2_tready,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  pkt_count
);

    logic   sof;
    route_t dest_r;
    route_t dest_new;
    route_t dest;
    logic   active;
    logic   xfer;
    logic   first_xfer;

    assign dest_new = route_decode(i_tuser == USER_W'(CTRL_PORT),
                                   i_tuser == USER_W'(TXDATA_PORT),
                                   i_tuser == USER_W'(RXFC_PORT));

    // First beat routes with zero latency; later beats follow the latched route.
    assign dest   = sof ? dest_new : dest_r;
    assign active = reset_n && !clear;

    always_comb begin
        i_tready = 1'b0;
        if (active) begin
            case (dest)
                ROUTE_CTRL: i_tready = o0_tready;
                ROUTE_TX:   i_tready = o1_tready;
                ROUTE_RXFC: i_tready = o2_tready;
                default:    i_tready = 1'b1;
            endcase
        end
    end

    assign o0_tdata  = i_tdata;
    assign o1_tdata  = i_tdata;
    assign o2_tdata  = i_tdata;
    assign o0_tlast  = i_tlast;
    assign o1_tlast  = i_tlast;
    assign o2_tlast  = i_tlast;
    assign o0_tvalid = active && i_tvalid && (dest == ROUTE_CTRL);
    assign o1_tvalid = active && i_tvalid && (dest == ROUTE_TX);
    assign o2_tvalid = active && i_tvalid && (dest == ROUTE_RXFC);

    assign xfer       = i_tvalid && i_tready;
    assign first_xfer = xfer && sof;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            sof    <= 1'b1;
            dest_r <= ROUTE_DROP;
        end else if (xfer) begin
            sof <= i_tlast;
            if (sof) begin
                dest_r <= dest_new;
            end
        end
    end

    stream_dispatch_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .inc    (first_xfer && (dest == ROUTE_DROP)),
        .count  (drop_count)
    );

    stream_dispatch_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_pkt_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .inc    (first_xfer && (dest != ROUTE_DROP)),
        .count  (pkt_count)
    );

endmodule

// File: tb/tb_stream_dispatch.sv
// tb_stream_dispatch: directed-vector bench for stream_dispatch (CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_stream_dispatch;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [63:0]      i_tdata;
    logic [15:0]      i_tuser;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [63:0]      o0_tdata, o1_tdata, o2_tdata;
    logic             o0_tlast, o1_tlast, o2_tlast;
    logic             o0_tvalid, o1_tvalid, o2_tvalid;
    logic             o0_tready, o1_tready, o2_tready;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] pkt_count;

    int vectors     = 0;
    int miscompares = 0;
    int o1_beats    = 0;
    int o1_base;

    always #5 clk = ~clk;

    stream_dispatch #(
        .CHDR_W     (64),
        .USER_W     (16),
        .CTRL_PORT  (49200),
        .TXDATA_PORT(49202),
        .RXFC_PORT  (49204),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .i_tdata   (i_tdata),
        .i_tuser   (i_tuser),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o0_tdata  (o0_tdata),
        .o0_tlast  (o0_tlast),
        .o0_tvalid (o0_tvalid),
        .o0_tready (o0_tready),
        .o1_tdata  (o1_tdata),
        .o1_tlast  (o1_tlast),
        .o1_tvalid (o1_tvalid),
        .o1_tready (o1_tready),
        .o2_tdata  (o2_tdata),
        .o2_tlast  (o2_tlast),
        .o2_tvalid (o2_tvalid),
        .o2_tready (o2_tready),
        .drop_count(drop_count),
        .pkt_count (pkt_count)
    );

    // Count beats actually accepted on o1 to catch lost or duplicated beats.
    always @(posedge clk) begin
        if (o1_tvalid && o1_tready) o1_beats <= o1_beats + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs 1ns later.
    // exp_dest 0..2 selects the expected output, 3 means no output valid.
    task automatic cyc(input string tag, input logic [63:0] d, input logic [15:0] u,
                       input logic l, input logic v, input logic rn, input logic cl,
                       input logic [2:0] rdy, input int exp_dest, input logic exp_rdy);
        logic [2:0]  ev;
        logic [63:0] od;
        logic        ol;
        @(negedge clk);
        reset_n  = rn;
        clear    = cl;
        i_tdata  = d;
        i_tuser  = u;
        i_tlast  = l;
        i_tvalid = v;
        {o2_tready, o1_tready, o0_tready} = rdy;
        #1;
        ev = (exp_dest < 3) ? 3'(1 << exp_dest) : 3'b000;
        check({tag, ".ready"}, 64'(i_tready), 64'(exp_rdy));
        check({tag, ".valid"}, 64'({o2_tvalid, o1_tvalid, o0_tvalid}), 64'(ev));
        if (exp_dest < 3) begin
            od = (exp_dest == 0) ? o0_tdata : (exp_dest == 1) ? o1_tdata : o2_tdata;
            ol = (exp_dest == 0) ? o0_tlast : (exp_dest == 1) ? o1_tlast : o2_tlast;
            check({tag, ".data"}, od, d);
            check({tag, ".last"}, 64'(ol), 64'(l));
        end
    endtask

    task automatic counts(input string tag, input int ep, input int ed);
        @(negedge clk);
        reset_n  = 1'b1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        #1;
        check({tag, ".pkt_count"}, 64'(pkt_count), 64'(ep));
        check({tag, ".drop_count"}, 64'(drop_count), 64'(ed));
    endtask

    int lens  [3] = '{3, 1, 2};
    int ports [3] = '{49202, 49204, 49202};
    int dests [3] = '{1, 2, 1};

    initial begin
        reset_n = 1'b0; clear = 1'b0; i_tdata = '0; i_tuser = '0; i_tlast = 1'b0;
        i_tvalid = 1'b0; o0_tready = 1'b1; o1_tready = 1'b1; o2_tready = 1'b1;

        // Reset holds off everything even with valid traffic presented.
        cyc("rst0", 64'h11, 16'd49200, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3, 1'b0);
        cyc("rst1", 64'h12, 16'd49202, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3, 1'b0);
        counts("rst", 0, 0);

        // 4-beat control packet.
        for (int i = 0; i < 4; i++)
            cyc("ctrl4", 64'hC0DE_0000_0000_0000 | 64'(i), (i == 0) ? 16'd49200 : 16'd0,
                i == 3, 1'b1, 1'b1, 1'b0, 3'b111, 0, 1'b1);
        counts("ctrl4", 1, 0);

        // Back-to-back tx / rxfc / tx packets, no idle cycles between.
        o1_base = o1_beats;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < lens[p]; i++)
                cyc("b2b", 64'hB2B0_0000_0000_0000 | 64'(p * 16 + i),
                    (i == 0) ? 16'(ports[p]) : 16'd7, i == lens[p] - 1,
                    1'b1, 1'b1, 1'b0, 3'b111, dests[p], 1'b1);
        counts("b2b", 4, 0);
        check("b2b.o1_beats", 64'(o1_beats - o1_base), 64'd5);

        // Unknown port drains at full rate even with every output stalled.
        for (int i = 0; i < 5; i++)
            cyc("drop5", 64'hD0D0_0000_0000_0000 | 64'(i), (i == 0) ? 16'd1234 : 16'd49200,
                i == 4, 1'b1, 1'b1, 1'b0, 3'b000, 3, 1'b1);
        counts("drop5", 4, 1);

        // o1 back-pressure; non-first tuser points at the ctrl port and must be ignored.
        o1_base = o1_beats;
        cyc("bp0", 64'hA0, 16'd49202, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 1, 1'b1);
        cyc("bp1", 64'hA1, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 1, 1'b0);
        cyc("bp2", 64'hA1, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 1, 1'b0);
        cyc("bp3", 64'hA1, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 1, 1'b1);
        cyc("bp4", 64'hA2, 16'd49200, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1, 1'b1);
        counts("bp", 5, 1);
        check("bp.o1_beats", 64'(o1_beats - o1_base), 64'd3);

        // Reset during beat 2 aborts the packet; next beat is a fresh first beat.
        cyc("mr0", 64'hE0, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 0, 1'b1);
        cyc("mr1", 64'hE1, 16'd49200, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3, 1'b0);
        cyc("mr2", 64'hE1, 16'd49200, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3, 1'b0);
        counts("mr", 0, 0);
        cyc("mr3", 64'hE2, 16'd49204, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 2, 1'b1);
        counts("mr_after", 1, 0);

        // Same sequence with soft clear.
        cyc("mc0", 64'hF0, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 0, 1'b1);
        cyc("mc1", 64'hF1, 16'd49200, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 3, 1'b0);
        counts("mc", 0, 0);
        cyc("mc2", 64'hF2, 16'd49204, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 2, 1'b1);
        counts("mc_after", 1, 0);

        // Drop counter saturation at 2^CNT_W-1.
        for (int i = 0; i < 15; i++)
            cyc("sat", 64'(i), 16'd1234, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 3, 1'b1);
        counts("sat15", 1, 15);
        cyc("sat16", 64'h16, 16'd1234, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 3, 1'b1);
        counts("sat16", 1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
